// File: rtl/lsu_agu_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lsu_agu_fifo
// Description : Memory stage directly after the LSU issue queue. Computes the
//               virtual address (base + sign-extended imm12), byte strobes and
//               lane-aligned store data for each issued load/store, flags
//               address-misaligned accesses (ALE), buffers the results in a
//               small in-order FIFO and presents the head entry either to the
//               DCache (valid/ready) or as a one-cycle ALE exception report.
//
// Optional    : LSU_ALIGN_CHECK_EN
//               defined   -> misaligned head entries are routed to exc_*;
//               undefined -> ALE flag forced 0, exc_* tied 0, every entry goes
//                            to the DCache with its raw address.
//
// Parameters  : DEPTH    - FIFO entries (power of two, >= 2)
//               ROB_ID_W - width of the ROB tag carried with each request
//
// Ports       : clk, rst_n (async active-low), flush (synchronous clear)
//               in_*  : issued op from the issue queue; in_ready_o is the
//                       issue queue's fifo_ready
//               req_* : DCache request channel (valid/ready)
//               exc_* : one-cycle ALE report (vaddr + ROB tag)
//
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_agu_fifo #(
    parameter int DEPTH    = 4,
    parameter int ROB_ID_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    // issue side
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         in_base_i,
    input  logic [11:0]         in_imm_i,
    input  logic [31:0]         in_wdata_i,
    input  logic [2:0]          in_op_i,
    input  logic [ROB_ID_W-1:0] in_rob_id_i,
    // DCache request side
    output logic                req_valid_o,
    input  logic                req_ready_i,
    output logic [31:0]         req_addr_o,
    output logic                req_we_o,
    output logic [3:0]          req_strb_o,
    output logic [31:0]         req_wdata_o,
    output logic [2:0]          req_op_o,
    output logic [ROB_ID_W-1:0] req_rob_id_o,
    // misaligned-address exception report
    output logic                exc_valid_o,
    output logic [31:0]         exc_vaddr_o,
    output logic [ROB_ID_W-1:0] exc_rob_id_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    // ------------------------------------------------------------------------
    // Address generation (purely combinational, captured at push)
    // ------------------------------------------------------------------------
    logic [31:0] w_addr;
    logic [1:0]  w_off;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_we;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic        w_ale;

    assign w_addr    = in_base_i + {{20{in_imm_i[11]}}, in_imm_i};
    assign w_off     = w_addr[1:0];
    assign w_is_byte = (in_op_i == 3'd0) || (in_op_i == 3'd3) || (in_op_i == 3'd5);
    assign w_is_half = (in_op_i == 3'd1) || (in_op_i == 3'd4) || (in_op_i == 3'd6);
    assign w_we      = (in_op_i >= 3'd5);

    // Half strobe shifted by 3 deliberately truncates to 4'b1000; only
    // reachable as a request when the alignment check is compiled out.
    always_comb begin
        w_strb = 4'b1111;
        if (w_is_byte) begin
            w_strb = 4'b0001 << w_off;
        end else if (w_is_half) begin
            w_strb = 4'b0011 << w_off;
        end
    end

    // Narrow store data is taken from the low bits of rd; the lane shift is
    // the only positioning applied.
    assign w_wdata = in_wdata_i << {w_off, 3'b000};

`ifdef LSU_ALIGN_CHECK_EN
    logic w_is_word;
    assign w_is_word = (in_op_i == 3'd2) || (in_op_i == 3'd7);
    assign w_ale     = (w_is_half && w_off[0]) || (w_is_word && (w_off != 2'b00));
`else
    assign w_ale     = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FIFO storage and control
    // ------------------------------------------------------------------------
    logic [31:0]         r_addr  [DEPTH];
    logic                r_we    [DEPTH];
    logic [3:0]          r_strb  [DEPTH];
    logic [31:0]         r_wdata [DEPTH];
    logic [2:0]          r_op    [DEPTH];
    logic [ROB_ID_W-1:0] r_rob   [DEPTH];
    logic                r_ale   [DEPTH];

    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic w_full;
    logic w_head_valid;
    logic w_head_ale;
    logic w_req_valid;
    logic w_exc_valid;
    logic w_push;
    logic w_pop;

    assign w_full       = (r_count == c_CNT_W'(DEPTH));
    assign w_head_valid = (r_count != '0);
    assign w_head_ale   = r_ale[r_rd_ptr];
    assign w_req_valid  = w_head_valid && !w_head_ale;
    assign w_exc_valid  = w_head_valid && w_head_ale;

    // in_ready follows the registered count, so a pop in this cycle does not
    // open a slot until the next one.
    assign w_push = in_valid_i && !w_full && !flush;
    // An ALE head is retired unconditionally in the cycle it is reported.
    assign w_pop  = (w_req_valid && req_ready_i) || w_exc_valid;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr [r_wr_ptr] <= w_addr;
            r_we   [r_wr_ptr] <= w_we;
            r_strb [r_wr_ptr] <= w_strb;
            r_wdata[r_wr_ptr] <= w_wdata;
            r_op   [r_wr_ptr] <= in_op_i;
            r_rob  [r_wr_ptr] <= in_rob_id_i;
            r_ale  [r_wr_ptr] <= w_ale;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            // A handshake completing this cycle is still taken by the DCache;
            // the FIFO simply empties.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Head output routing; fields are zero whenever their channel is idle so
    // the outputs read as 0 out of reset and when empty.
    // ------------------------------------------------------------------------
    assign in_ready_o   = !w_full;

    assign req_valid_o  = w_req_valid;
    assign req_addr_o   = w_req_valid ? r_addr [r_rd_ptr] : 32'd0;
    assign req_we_o     = w_req_valid ? r_we   [r_rd_ptr] : 1'b0;
    assign req_strb_o   = w_req_valid ? r_strb [r_rd_ptr] : 4'd0;
    assign req_wdata_o  = w_req_valid ? r_wdata[r_rd_ptr] : 32'd0;
    assign req_op_o     = w_req_valid ? r_op   [r_rd_ptr] : 3'd0;
    assign req_rob_id_o = w_req_valid ? r_rob  [r_rd_ptr] : '0;

`ifdef LSU_ALIGN_CHECK_EN
    assign exc_valid_o  = w_exc_valid;
    assign exc_vaddr_o  = w_exc_valid ? r_addr[r_rd_ptr] : 32'd0;
    assign exc_rob_id_o = w_exc_valid ? r_rob [r_rd_ptr] : '0;
`else
    assign exc_valid_o  = 1'b0;
    assign exc_vaddr_o  = 32'd0;
    assign exc_rob_id_o = '0;
`endif

endmodule
`default_nettype wire

// File: doc/lsu_agu_fifo.md
Name: lsu_agu_fifo

Overview:
- Memory stage directly downstream of the LSU issue queue.
- Accepts one issued load/store per cycle and computes the virtual address (base + sign-extended immediate). Derives byte strobes, lane-aligns store data, and checks alignment.
- Buffers requests in a small in-order FIFO and presents them to the DCache with a valid/ready handshake.
- in_ready_o drives the issue queue's fifo_ready input.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- ROB_ID_W, 6, width of ROB id tag carried with each request.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush; discards all entries
- in_valid_i  in  1  issued LSU op valid
- in_ready_o  out  1  FIFO can accept (to issue queue fifo_ready)
- in_base_i  in  32  rj operand
- in_imm_i  in  12  signed offset
- in_wdata_i  in  32  store data (rd operand)
- in_op_i  in  3  0 LD.B, 1 LD.H, 2 LD.W, 3 LD.BU, 4 LD.HU, 5 ST.B, 6 ST.H, 7 ST.W
- in_rob_id_i  in  ROB_ID_W  ROB tag
- req_valid_o  out  1  DCache request valid
- req_ready_i  in  1  DCache accepts request
- req_addr_o  out  32  virtual address
- req_we_o  out  1  1 = store
- req_strb_o  out  4  byte enables
- req_wdata_o  out  32  lane-aligned store data
- req_op_o  out  3  original op code (for load extension)
- req_rob_id_o  out  ROB_ID_W  ROB tag
- exc_valid_o  out  1  one-cycle address-misaligned (ALE) report
- exc_vaddr_o  out  32  faulting address
- exc_rob_id_o  out  ROB_ID_W  faulting ROB tag

Behaviour:
- Reset: asynchronous on rst_n low. Pointers and count cleared; all outputs 0 except in_ready_o = 1.
- Address: addr = in_base_i + sext(in_imm_i), modulo 2^32.
- Byte strobes, o = addr[1:0]:
  - byte ops: 4'b0001 << o
  - half ops: 4'b0011 << o
  - word ops: 4'b1111
- Store data: req_wdata_o = in_wdata_i << (8*o). Byte/half data uses the low bits of rd, replicated through the shift only.
- Misaligned (ALE): half with o[0] = 1, or word with o != 0.
- All AGU results are computed combinationally and stored into the entry at push. Outputs come from the head entry; there is no input-to-output bypass.
- Push: in_valid_i & in_ready_o & !flush.
- Pop: head valid and either (req_valid_o & req_ready_i) or (exc_valid_o). The exception path pops unconditionally in 1 cycle.
- Head output routing:
  - head not ALE: req_valid_o = 1, exc_valid_o = 0.
  - head ALE: exc_valid_o = 1, req_valid_o = 0.
- Latency: push in cycle N into an empty FIFO, head visible in cycle N+1.
- in_ready_o = (count != DEPTH). A same-cycle pop does not raise it.
- count width = clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: push ignored. Empty: req_valid_o = exc_valid_o = 0.
- Output stability: req_* stay stable while req_valid_o & !req_ready_i.
- Flush (synchronous):
  - next cycle count = 0, pointers = 0, req_valid_o = exc_valid_o = 0.
  - a push in the flush cycle is dropped.
  - a handshake completing in the flush cycle is still consumed by the DCache; the FIFO clears regardless.
- Reset mid-operation: all state clears immediately; no partial handshake is retained.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: ALE detection and routing as above.
- Undefined:
  - ALE flag is forced 0; exc_valid_o, exc_vaddr_o and exc_rob_id_o are tied 0.
  - Every entry goes to the DCache with the raw address.
  - Strobes are computed as above; the shifted half strobe for o = 3 truncates to 4'b1000.

Test Plan:
- Reset then one LD.W, base=0x1000, imm=0x004, DCache ready -> cycle+1: req_valid_o=1, addr=0x1004, strb=4'hF, we=0. Entry pops; FIFO empty after.
- ST.B, base=0x2000, imm=-1 (12'hFFF), wdata=0xAB -> addr=0x1FFF, strb=4'b1000, wdata=0xAB000000, we=1.
- req_ready_i=0, push 4 ops -> in_ready_o=0 after the 4th push; 5th push ignored. Raise ready -> 4 requests emitted in order with stable fields while stalled.
- LD.H at addr 0x3001 (ALSU_ALIGN_CHECK_EN defined) -> exc_valid_o=1 for one cycle, exc_vaddr_o=0x3001, req_valid_o stays 0, entry popped. Without the macro: req_valid_o=1, strb=4'b0110.
- 3 entries queued, ready=0, assert flush with in_valid_i=1 -> next cycle req_valid_o=0, in_ready_o=1, count=0; flushed-cycle input never appears at the output.
- Full FIFO, ready=1, in_valid_i=1 continuously -> one pop per cycle. in_ready_o goes high the cycle after the first pop; steady throughput of 1 op/cycle thereafter.
